// File: rtl/elevator_request_scheduler.sv
// rtl/elevator_request_scheduler.sv - park/retrieve request queues with round-robin command issue to the elevator
// Two 4-deep plate FIFOs feed a single outstanding command; leakage halts motion without losing an offered command.
module elevator_request_scheduler (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_req,
    input  logic [15:0] in_plate,
    input  logic        out_req,
    input  logic [15:0] out_plate,
    input  logic        leakage,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_dir,
    output logic [15:0] cmd_plate,
    input  logic        cmd_done,
    output logic [2:0]  in_count,
    output logic [2:0]  out_count,
    output logic        busy,
    output logic        halted,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, HALT} state_t;

    state_t      state;
    logic        pending;
    logic        last_grant_out;

    logic [15:0] in_mem  [4];
    logic [15:0] out_mem [4];
    logic [1:0]  in_wr, in_rd, out_wr, out_rd;

    logic        in_push, in_drop, in_pop;
    logic        out_push, out_drop, out_pop;
    logic        in_any, out_any, grant_out, pop_en;
    logic [8:0]  drop_sum;

    // Fullness is judged on the registered count, so a same-cycle pop never makes room for a push.
    always_comb begin
        in_push   = in_req && (in_plate != 16'd0) && (in_count != 3'd4);
        in_drop   = in_req && !in_push;
        out_push  = out_req && (out_plate != 16'd0) && (out_count != 3'd4);
        out_drop  = out_req && !out_push;
        in_any    = (in_count != 3'd0);
        out_any   = (out_count != 3'd0);
        grant_out = out_any && (!in_any || !last_grant_out);
        pop_en    = (state == IDLE) && !leakage && (in_any || out_any);
        in_pop    = pop_en && !grant_out;
        out_pop   = pop_en && grant_out;
        drop_sum  = {1'b0, drop_count} + {8'd0, in_drop} + {8'd0, out_drop};
    end

    always_ff @(posedge clock) begin
        if (in_push) begin
            in_mem[in_wr] <= in_plate;
        end
        if (out_push) begin
            out_mem[out_wr] <= out_plate;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_wr      <= 2'd0;
            in_rd      <= 2'd0;
            in_count   <= 3'd0;
            out_wr     <= 2'd0;
            out_rd     <= 2'd0;
            out_count  <= 3'd0;
            drop_count <= 8'd0;
        end else begin
            if (in_push) begin
                in_wr <= in_wr + 2'd1;
            end
            if (in_pop) begin
                in_rd <= in_rd + 2'd1;
            end
            if (out_push) begin
                out_wr <= out_wr + 2'd1;
            end
            if (out_pop) begin
                out_rd <= out_rd + 2'd1;
            end
            in_count   <= in_count + {2'd0, in_push} - {2'd0, in_pop};
            out_count  <= out_count + {2'd0, out_push} - {2'd0, out_pop};
            drop_count <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end

    // A freshly popped command spends one cycle in ISSUE with cmd_valid low before it is offered;
    // a command re-offered out of HALT is already loaded, so it is offered on the exit edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            pending        <= 1'b0;
            last_grant_out <= 1'b1;
            cmd_valid      <= 1'b0;
            cmd_dir        <= 1'b0;
            cmd_plate      <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_valid <= 1'b0;
                    if (leakage) begin
                        state   <= HALT;
                        pending <= 1'b0;
                    end else if (pop_en) begin
                        cmd_dir        <= grant_out;
                        cmd_plate      <= grant_out ? out_mem[out_rd] : in_mem[in_rd];
                        last_grant_out <= grant_out;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (leakage) begin
                        state     <= HALT;
                        pending   <= 1'b1;
                        cmd_valid <= 1'b0;
                    end else if (cmd_valid && cmd_ready) begin
                        state     <= WAIT_DONE;
                        cmd_valid <= 1'b0;
                    end else begin
                        cmd_valid <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    cmd_valid <= 1'b0;
                    if (cmd_done) begin
                        state   <= leakage ? HALT : IDLE;
                        pending <= 1'b0;
                    end
                end
                HALT: begin
                    if (!leakage) begin
                        state     <= pending ? ISSUE : IDLE;
                        cmd_valid <= pending;
                        pending   <= 1'b0;
                    end else begin
                        cmd_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign halted = (state == HALT);

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// tb/tb_elevator_request_scheduler.sv - randomized and directed checks against a queue-based reference model
module tb_elevator_request_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_req, out_req, leakage, cmd_ready, cmd_done;
    logic [15:0] in_plate, out_plate;
    logic        cmd_valid, cmd_dir, busy, halted;
    logic [15:0] cmd_plate;
    logic [2:0]  in_count, out_count;
    logic [7:0]  drop_count;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    elevator_request_scheduler dut (
        .clock      (clock),
        .reset      (reset),
        .in_req     (in_req),
        .in_plate   (in_plate),
        .out_req    (out_req),
        .out_plate  (out_plate),
        .leakage    (leakage),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_plate  (cmd_plate),
        .cmd_done   (cmd_done),
        .in_count   (in_count),
        .out_count  (out_count),
        .busy       (busy),
        .halted     (halted),
        .drop_count (drop_count)
    );

    // Reference model: plate queues plus flags describing the command's life cycle.
    int unsigned m_inq[$];
    int unsigned m_outq[$];
    bit          m_active, m_accepted, m_halted, m_offer, m_last_out, m_dir;
    int unsigned m_plate, m_drops;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_inq.delete();
        m_outq.delete();
        m_active = 0; m_accepted = 0; m_halted = 0; m_offer = 0;
        m_last_out = 1; m_dir = 0; m_plate = 0; m_drops = 0;
    endtask

    task automatic model_step();
        bit pi, po, di, dro, take_out;
        pi  = in_req && (in_plate != 0) && (m_inq.size() < 4);
        di  = in_req && !pi;
        po  = out_req && (out_plate != 0) && (m_outq.size() < 4);
        dro = out_req && !po;
        if (m_halted) begin
            if (!leakage) begin
                m_halted = 0;
                if (m_active) m_offer = 1;
            end
        end else if (!m_active) begin
            if (leakage) begin
                m_halted = 1;
            end else if (m_inq.size() > 0 || m_outq.size() > 0) begin
                take_out = (m_inq.size() == 0) || (m_outq.size() > 0 && !m_last_out);
                if (take_out) m_plate = m_outq.pop_front();
                else          m_plate = m_inq.pop_front();
                m_dir = take_out;
                m_last_out = take_out;
                m_active = 1;
                m_offer = 0;
            end
        end else if (!m_accepted) begin
            if (leakage) begin
                m_halted = 1; m_offer = 0;
            end else if (m_offer && cmd_ready) begin
                m_accepted = 1; m_offer = 0;
            end else begin
                m_offer = 1;
            end
        end else if (cmd_done) begin
            m_active = 0; m_accepted = 0; m_halted = leakage;
        end
        if (pi) m_inq.push_back(in_plate);
        if (po) m_outq.push_back(out_plate);
        m_drops = m_drops + di + dro;
        if (m_drops > 255) m_drops = 255;
    endtask

    task automatic compare_all();
        check("cmd_valid", cmd_valid, m_offer);
        check("cmd_dir", cmd_dir, m_dir);
        check("cmd_plate", cmd_plate, m_plate);
        check("in_count", in_count, m_inq.size());
        check("out_count", out_count, m_outq.size());
        check("busy", busy, m_active || m_halted);
        check("halted", halted, m_halted);
        check("drop_count", drop_count, m_drops);
    endtask

    task automatic clear_inputs();
        in_req = 0; out_req = 0; in_plate = 0; out_plate = 0;
        leakage = 0; cmd_ready = 0; cmd_done = 0;
    endtask

    task automatic step();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
        @(negedge clock);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        compare_all();
        reset = 1;
    endtask

    int unsigned got[$];
    int unsigned exp_order[4];

    initial begin
        clear_inputs();
        reset = 0;
        model_reset();
        @(negedge clock);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_count, 0);
        do_reset();

        // Single park: request at edge 1, offered from edge 3, accepted at edge 4.
        in_req = 1; in_plate = 16'h1234;
        step();
        in_req = 0;
        step();
        check("park_e2_valid", cmd_valid, 0);
        step();
        check("park_e3_valid", cmd_valid, 1);
        check("park_e3_plate", cmd_plate, 16'h1234);
        check("park_e3_dir", cmd_dir, 0);
        cmd_ready = 1;
        step();
        check("park_e4_valid", cmd_valid, 0);
        check("park_e4_busy", busy, 1);
        cmd_ready = 0; cmd_done = 1;
        step();
        cmd_done = 0;
        check("park_done_busy", busy, 0);

        // Round-robin between queues.
        do_reset();
        exp_order[0] = 16'h1111; exp_order[1] = 16'hA001;
        exp_order[2] = 16'h2222; exp_order[3] = 16'hA002;
        got.delete();
        cmd_ready = 1;
        in_req = 1; in_plate = 16'h1111; out_req = 1; out_plate = 16'hA001;
        step();
        in_plate = 16'h2222; out_plate = 16'hA002;
        step();
        in_req = 0; out_req = 0;
        for (int i = 0; i < 80 && got.size() < 4; i++) begin
            cmd_done = m_accepted;
            if (cmd_valid && cmd_ready) got.push_back(cmd_plate);
            step();
        end
        check("rr_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) check("rr_order", got[i], exp_order[i]);
        end
        cmd_done = 0; cmd_ready = 0;

        // Overflow: six back-to-back parks with the controller never ready.
        do_reset();
        for (int p = 1; p <= 6; p++) begin
            in_req = 1; in_plate = 16'(p);
            step();
        end
        check("ovf_in_count", in_count, 4);
        check("ovf_drop", drop_count, 1);
        check("ovf_plate", cmd_plate, 16'h0001);
        out_req = 1; out_plate = 16'h0000; in_req = 0;
        step();
        out_req = 0;
        check("zero_plate_drop", drop_count, 2);

        // Leakage while offered, then while executing.
        do_reset();
        in_req = 1; in_plate = 16'h0BEE;
        step();
        in_req = 0;
        step();
        step();
        leakage = 1;
        step();
        check("leak_issue_halted", halted, 1);
        check("leak_issue_valid", cmd_valid, 0);
        leakage = 0;
        step();
        check("leak_reoffer_valid", cmd_valid, 1);
        check("leak_reoffer_plate", cmd_plate, 16'h0BEE);
        cmd_ready = 1;
        step();
        cmd_ready = 0; leakage = 1;
        step();
        check("leak_wait_halted", halted, 0);
        cmd_done = 1;
        step();
        cmd_done = 0;
        check("leak_done_halted", halted, 1);
        leakage = 0;
        step();
        check("leak_clear_busy", busy, 0);

        // Asynchronous reset while a command executes with three entries queued.
        do_reset();
        cmd_ready = 1; in_req = 1;
        for (int p = 1; p <= 4; p++) begin
            in_plate = 16'(p * 16'h11);
            step();
        end
        in_req = 0; cmd_ready = 0;
        check("pre_rst_in_count", in_count, 3);
        check("pre_rst_busy", busy, 1);
        #2 reset = 0;
        #1;
        check("arst_cmd_valid", cmd_valid, 0);
        check("arst_cmd_dir", cmd_dir, 0);
        check("arst_cmd_plate", cmd_plate, 0);
        check("arst_busy", busy, 0);
        check("arst_halted", halted, 0);
        check("arst_in_count", in_count, 0);
        check("arst_drop", drop_count, 0);
        model_reset();
        @(negedge clock);
        reset = 1;
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic with leakage episodes.
        for (int i = 0; i < 3000; i++) begin
            in_req    = ($urandom_range(0, 2) == 0);
            in_plate  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            out_req   = ($urandom_range(0, 2) == 0);
            out_plate = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            cmd_ready = $urandom_range(0, 1) == 1;
            cmd_done  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) leakage = ~leakage;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
